// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-port constants, port FSM state type and access helpers
package mem_pkg;

  // Request function codes
  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  // Access type codes
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } port_state_e;

  function automatic logic typ_legal(input logic [2:0] typ);
    return (typ == MT_B) || (typ == MT_H) || (typ == MT_W) ||
           (typ == MT_BU) || (typ == MT_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] typ, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if ((typ == MT_H) || (typ == MT_HU)) bad = off[0];
    if (typ == MT_W)                     bad = (off != 2'b00);
    return bad;
  endfunction

  // Select the addressed lane(s) of a word and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  typ);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (typ)
      MT_B:    res = {{24{sh[7]}}, sh[7:0]};
      MT_BU:   res = {24'h0, sh[7:0]};
      MT_H:    res = {{16{sh[15]}}, sh[15:0]};
      MT_HU:   res = {16'h0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - instruction and data memory port bundle
// Ports: i_req_* / i_resp_* fetch channel, d_req_* / d_resp_* load/store channel.
// master = core side (drives requests), slave = memory side (drives ready/responses).
interface mem_responder_if #(
  parameter int ADDR_W = 32
) ();
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_resp_valid;
  logic [31:0]       i_resp_data;
  logic              i_resp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic [31:0]       d_req_data;
  logic              d_req_fcn;
  logic [2:0]        d_req_typ;
  logic              d_resp_valid;
  logic [31:0]       d_resp_data;
  logic              d_resp_err;

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
    output d_req_valid, d_req_addr, d_req_data, d_req_fcn, d_req_typ,
    input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err
  );

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
    input  d_req_valid, d_req_addr, d_req_data, d_req_fcn, d_req_typ,
    output d_req_ready, d_resp_valid, d_resp_data, d_resp_err
  );
endinterface

// File: rtl/mem_port_fsm.sv
// rtl/mem_port_fsm.sv - one memory port: handshake, latency countdown, response register
// Ports: clk, rst (async active-low); req_valid_i/req_ready_o handshake, accept_o
// marks the accept edge; rsp_data_i/rsp_err_i are captured on accept and presented
// on resp_data_o/resp_err_o; resp_valid_o pulses LATENCY cycles after accept.
module mem_port_fsm
  import mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  output logic        accept_o,
  input  logic [31:0] rsp_data_i,
  input  logic        rsp_err_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  port_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  assign req_ready_o  = (state_q != WAIT);
  // No handshake is honoured while reset is held, even though ready reads 1.
  assign accept_o     = req_valid_i && req_ready_o && rst;
  assign resp_valid_o = (state_q == RESP);
  assign resp_data_o  = data_q;
  assign resp_err_o   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept_o) begin
          data_d = rsp_data_i;
          err_d  = rsp_err_i;
          if (CNT_LOAD == 4'd0) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      WAIT: begin
        // Leaving on count 1 makes the pulse land exactly LATENCY cycles after accept.
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - dual-port scratchpad responder with fixed response latency
// Ports: clk, rst (async active-low), bus (mem_responder_if.slave) carrying the
// fetch port (i_*) and the load/store port (d_*). Owns the byte-lane word array,
// load lane select/extension, store byte enables and the error decode.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int              IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0] DEPTH_BYTES = (ADDR_W + 1)'(DEPTH_WORDS) << 2;

  logic [7:0] lane0 [DEPTH_WORDS];
  logic [7:0] lane1 [DEPTH_WORDS];
  logic [7:0] lane2 [DEPTH_WORDS];
  logic [7:0] lane3 [DEPTH_WORDS];

  logic [ADDR_W-1:0] d_off, i_off;
  logic [IDX_W-1:0]  d_idx, i_idx;
  logic              d_oor, i_oor;
  logic              d_err, i_err;
  logic [31:0]       d_word, i_word;
  logic [31:0]       d_rdata, i_rdata;
  logic              d_accept, i_accept;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_wdata;

  // Address decode for both ports; unsigned subtraction wraps below BASE, so
  // the explicit lower-bound compare is kept.
  always_comb begin
    d_off = bus.d_req_addr - BASE;
    i_off = bus.i_req_addr - BASE;
    d_oor = (bus.d_req_addr < BASE) || ({1'b0, d_off} >= DEPTH_BYTES);
    i_oor = (bus.i_req_addr < BASE) || ({1'b0, i_off} >= DEPTH_BYTES);
    d_idx = d_off[IDX_W+1:2];
    i_idx = i_off[IDX_W+1:2];
  end

  assign d_err = d_oor || !typ_legal(bus.d_req_typ) ||
                 misaligned(bus.d_req_typ, bus.d_req_addr[1:0]);
  // Fetch port is permanently a word read.
  assign i_err = i_oor || misaligned(MT_W, bus.i_req_addr[1:0]);

  // Asynchronous array read: captured into the response register on the accept
  // edge, so a same-edge store to the word is not yet visible (old data returned).
  assign d_word = {lane3[d_idx], lane2[d_idx], lane1[d_idx], lane0[d_idx]};
  assign i_word = {lane3[i_idx], lane2[i_idx], lane1[i_idx], lane0[i_idx]};

  assign d_rdata = (d_err || (bus.d_req_fcn == M_XWR)) ? 32'h0 :
                   load_extend(d_word, bus.d_req_addr[1:0], bus.d_req_typ);
  assign i_rdata = i_err ? 32'h0 : i_word;

  // Store lane enables and replicated write data.
  always_comb begin
    d_be    = 4'b0000;
    d_wdata = bus.d_req_data;
    case (bus.d_req_typ)
      MT_B, MT_BU: begin
        d_be    = 4'b0001 << bus.d_req_addr[1:0];
        d_wdata = {4{bus.d_req_data[7:0]}};
      end
      MT_H, MT_HU: begin
        d_be    = bus.d_req_addr[1] ? 4'b1100 : 4'b0011;
        d_wdata = {2{bus.d_req_data[15:0]}};
      end
      MT_W: begin
        d_be    = 4'b1111;
        d_wdata = bus.d_req_data;
      end
      default: begin
        d_be    = 4'b0000;
        d_wdata = bus.d_req_data;
      end
    endcase
  end

  assign d_we = d_accept && (bus.d_req_fcn == M_XWR) && !d_err;

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (d_we) begin
      if (d_be[0]) lane0[d_idx] <= d_wdata[7:0];
      if (d_be[1]) lane1[d_idx] <= d_wdata[15:8];
      if (d_be[2]) lane2[d_idx] <= d_wdata[23:16];
      if (d_be[3]) lane3[d_idx] <= d_wdata[31:24];
    end
  end

  mem_port_fsm #(.LATENCY(LATENCY)) u_i_port (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (bus.i_req_valid),
    .req_ready_o  (bus.i_req_ready),
    .accept_o     (i_accept),
    .rsp_data_i   (i_rdata),
    .rsp_err_i    (i_err),
    .resp_valid_o (bus.i_resp_valid),
    .resp_data_o  (bus.i_resp_data),
    .resp_err_o   (bus.i_resp_err)
  );

  mem_port_fsm #(.LATENCY(LATENCY)) u_d_port (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (bus.d_req_valid),
    .req_ready_o  (bus.d_req_ready),
    .accept_o     (d_accept),
    .rsp_data_i   (d_rdata),
    .rsp_err_i    (d_err),
    .resp_valid_o (bus.d_resp_valid),
    .resp_data_o  (bus.d_resp_data),
    .resp_err_o   (bus.d_resp_err)
  );

  logic unused_i_accept;
  assign unused_i_accept = i_accept;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at latencies 1, 3 and 4
module tb_mem_responder;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];

  mem_responder_if #(.ADDR_W(32)) ifc1 ();
  mem_responder_if #(.ADDR_W(32)) ifc3 ();
  mem_responder_if #(.ADDR_W(32)) ifc4 ();

  mem_responder #(.LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
  mem_responder #(.LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(ifc3.slave));
  mem_responder #(.LATENCY(4)) u4 (.clk(clk), .rst(rst), .bus(ifc4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response channel ids: 0/1 = u1 d/i, 2/3 = u3 d/i, 4/5 = u4 d/i.
  logic        rv [6];
  logic [31:0] rd [6];
  logic        re [6];
  assign rv[0] = ifc1.d_resp_valid; assign rd[0] = ifc1.d_resp_data; assign re[0] = ifc1.d_resp_err;
  assign rv[1] = ifc1.i_resp_valid; assign rd[1] = ifc1.i_resp_data; assign re[1] = ifc1.i_resp_err;
  assign rv[2] = ifc3.d_resp_valid; assign rd[2] = ifc3.d_resp_data; assign re[2] = ifc3.d_resp_err;
  assign rv[3] = ifc3.i_resp_valid; assign rd[3] = ifc3.i_resp_data; assign re[3] = ifc3.i_resp_err;
  assign rv[4] = ifc4.d_resp_valid; assign rd[4] = ifc4.d_resp_data; assign re[4] = ifc4.d_resp_err;
  assign rv[5] = ifc4.i_resp_valid; assign rd[5] = ifc4.i_resp_data; assign re[5] = ifc4.i_resp_err;

  always @(negedge clk) begin
    int idx;
    int j;
    for (int k = 0; k < 6; k++) begin
      if (rv[k]) begin
        idx = -1;
        for (int m = 0; m < sb.size(); m++)
          if (idx < 0 && sb[m].id == k) idx = m;
        if (idx < 0) begin
          chk($sformatf("p%0d_unexpected", k), {31'b0, rv[k]}, 32'h0);
        end else begin
          chk($sformatf("p%0d_data", k), rd[k], sb[idx].data);
          chk($sformatf("p%0d_err", k), {31'b0, re[k]}, {31'b0, sb[idx].err});
          chk($sformatf("p%0d_cycle", k), cyc, sb[idx].due);
          sb.delete(idx);
        end
      end
    end
    j = 0;
    while (j < sb.size()) begin
      if (sb[j].due < cyc) begin
        chk($sformatf("p%0d_late", sb[j].id), cyc, sb[j].due);
        sb.delete(j);
      end else begin
        j++;
      end
    end
  end

  function automatic int pid(input int s);
    return (s == 1) ? 0 : (s == 3) ? 2 : 4;
  endfunction

  task automatic set_d(input int s, input logic v, input logic [31:0] a,
                       input logic [31:0] wd, input logic f, input logic [2:0] t);
    case (s)
      1: begin ifc1.d_req_valid = v; ifc1.d_req_addr = a; ifc1.d_req_data = wd; ifc1.d_req_fcn = f; ifc1.d_req_typ = t; end
      3: begin ifc3.d_req_valid = v; ifc3.d_req_addr = a; ifc3.d_req_data = wd; ifc3.d_req_fcn = f; ifc3.d_req_typ = t; end
      default: begin ifc4.d_req_valid = v; ifc4.d_req_addr = a; ifc4.d_req_data = wd; ifc4.d_req_fcn = f; ifc4.d_req_typ = t; end
    endcase
  endtask

  task automatic set_i(input int s, input logic v, input logic [31:0] a);
    case (s)
      1: begin ifc1.i_req_valid = v; ifc1.i_req_addr = a; end
      3: begin ifc3.i_req_valid = v; ifc3.i_req_addr = a; end
      default: begin ifc4.i_req_valid = v; ifc4.i_req_addr = a; end
    endcase
  endtask

  function automatic logic d_rdy(input int s);
    return (s == 1) ? ifc1.d_req_ready : (s == 3) ? ifc3.d_req_ready : ifc4.d_req_ready;
  endfunction

  function automatic logic i_rdy(input int s);
    return (s == 1) ? ifc1.i_req_ready : (s == 3) ? ifc3.i_req_ready : ifc4.i_req_ready;
  endfunction

  // Called at a negedge; the accept lands on the next posedge, the response
  // is seen LATENCY (= s) negedges later.
  task automatic d_op(input int s, input logic [31:0] a, input logic [31:0] wd,
                      input logic f, input logic [2:0] t,
                      input logic [31:0] ed, input logic ee, input logic push);
    int n;
    set_d(s, 1'b1, a, wd, f, t);
    n = 0;
    while (!d_rdy(s) && n < 50) begin @(negedge clk); n++; end
    chk("d_ready", {31'b0, d_rdy(s)}, 32'h1);
    if (push) sb.push_back('{pid(s), ed, ee, cyc + s});
    @(negedge clk);
    set_d(s, 1'b0, 32'h0, 32'h0, M_XRD, MT_W);
  endtask

  task automatic i_op(input int s, input logic [31:0] a,
                      input logic [31:0] ed, input logic ee);
    int n;
    set_i(s, 1'b1, a);
    n = 0;
    while (!i_rdy(s) && n < 50) begin @(negedge clk); n++; end
    chk("i_ready", {31'b0, i_rdy(s)}, 32'h1);
    sb.push_back('{pid(s) + 1, ed, ee, cyc + s});
    @(negedge clk);
    set_i(s, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] fa [3];
    logic [31:0] fd [3];
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      set_d(s, 1'b0, 32'h0, 32'h0, M_XRD, MT_W);
      set_i(s, 1'b0, 32'h0);
    end
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_d_valid", {31'b0, ifc1.d_resp_valid}, 32'h0);
    chk("rst_d_data", ifc1.d_resp_data, 32'h0);
    chk("rst_d_err", {31'b0, ifc1.d_resp_err}, 32'h0);
    chk("rst_i_valid", {31'b0, ifc1.i_resp_valid}, 32'h0);
    chk("rst_d_ready", {31'b0, ifc1.d_req_ready}, 32'h1);
    chk("rst_i_ready", {31'b0, ifc1.i_req_ready}, 32'h1);
    rst = 1'b1;
    @(negedge clk);

    // LATENCY=1 loads/stores and extension
    d_op(1, 32'h100, 32'hDEADBEEF, M_XWR, MT_W, 32'h0, 1'b0, 1'b1);
    d_op(1, 32'h103, 32'h0, M_XRD, MT_B, 32'hFFFFFFDE, 1'b0, 1'b1);
    @(negedge clk);
    chk("hold_valid", {31'b0, ifc1.d_resp_valid}, 32'h0);
    chk("hold_data", ifc1.d_resp_data, 32'hFFFFFFDE);
    d_op(1, 32'h103, 32'h0, M_XRD, MT_BU, 32'h000000DE, 1'b0, 1'b1);
    d_op(1, 32'h102, 32'h0, M_XRD, MT_HU, 32'h0000DEAD, 1'b0, 1'b1);
    d_op(1, 32'h102, 32'h0, M_XRD, MT_H, 32'hFFFFDEAD, 1'b0, 1'b1);
    d_op(1, 32'h100, 32'h0, M_XRD, MT_B, 32'hFFFFFFEF, 1'b0, 1'b1);
    d_op(1, 32'h101, 32'h0, M_XRD, MT_BU, 32'h000000BE, 1'b0, 1'b1);
    d_op(1, 32'h100, 32'h0, M_XRD, MT_W, 32'hDEADBEEF, 1'b0, 1'b1);

    // Error cases: no data, no array write
    d_op(1, 32'h102, 32'h0, M_XRD, MT_W, 32'h0, 1'b1, 1'b1);
    d_op(1, 32'h101, 32'h0000FFFF, M_XWR, MT_H, 32'h0, 1'b1, 1'b1);
    d_op(1, 32'h100, 32'h0, M_XRD, 3'd4, 32'h0, 1'b1, 1'b1);
    d_op(1, 32'h100, 32'h11111111, M_XWR, 3'd7, 32'h0, 1'b1, 1'b1);
    d_op(1, 32'h0001_0000, 32'h0, M_XRD, MT_W, 32'h0, 1'b1, 1'b1);
    d_op(1, 32'h0001_0000, 32'h22222222, M_XWR, MT_W, 32'h0, 1'b1, 1'b1);
    d_op(1, 32'h100, 32'h0, M_XRD, MT_W, 32'hDEADBEEF, 1'b0, 1'b1);

    // Partial stores
    d_op(1, 32'h101, 32'h00000055, M_XWR, MT_B, 32'h0, 1'b0, 1'b1);
    d_op(1, 32'h100, 32'h0, M_XRD, MT_W, 32'hDEAD55EF, 1'b0, 1'b1);
    d_op(1, 32'h102, 32'hAAAA1234, M_XWR, MT_H, 32'h0, 1'b0, 1'b1);
    d_op(1, 32'h100, 32'h0, M_XRD, MT_W, 32'h123455EF, 1'b0, 1'b1);
    d_op(1, 32'hFFFC, 32'hFFFF0000, M_XWR, MT_W, 32'h0, 1'b0, 1'b1);
    d_op(1, 32'hFFFE, 32'h0, M_XRD, MT_HU, 32'h0000FFFF, 1'b0, 1'b1);
    d_op(1, 32'hFFFC, 32'h0, M_XRD, MT_H, 32'h0, 1'b0, 1'b1);

    // Same-edge fetch and store to one word: fetch sees the old value
    d_op(1, 32'h200, 32'h0, M_XWR, MT_W, 32'h0, 1'b0, 1'b1);
    set_i(1, 1'b1, 32'h200);
    set_d(1, 1'b1, 32'h200, 32'h12345678, M_XWR, MT_W);
    sb.push_back('{1, 32'h0, 1'b0, cyc + 1});
    sb.push_back('{0, 32'h0, 1'b0, cyc + 1});
    @(negedge clk);
    set_i(1, 1'b0, 32'h0);
    set_d(1, 1'b0, 32'h0, 32'h0, M_XRD, MT_W);
    i_op(1, 32'h200, 32'h12345678, 1'b0);
    i_op(1, 32'h202, 32'h0, 1'b1);
    i_op(1, 32'h0001_0000, 32'h0, 1'b1);

    // LATENCY=3: held fetch valid, ready low 2 of every 3 cycles
    fa[0] = 32'h0; fa[1] = 32'h4; fa[2] = 32'h8;
    fd[0] = 32'h11111111; fd[1] = 32'h22222222; fd[2] = 32'h33333333;
    for (int k = 0; k < 3; k++) d_op(3, fa[k], fd[k], M_XWR, MT_W, 32'h0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      set_i(3, 1'b1, fa[k]);
      chk("l3_ready_hi", {31'b0, ifc3.i_req_ready}, 32'h1);
      sb.push_back('{3, fd[k], 1'b0, cyc + 3});
      @(negedge clk);
      chk("l3_ready_lo1", {31'b0, ifc3.i_req_ready}, 32'h0);
      @(negedge clk);
      chk("l3_ready_lo2", {31'b0, ifc3.i_req_ready}, 32'h0);
      @(negedge clk);
    end
    set_i(3, 1'b0, 32'h0);
    repeat (4) @(negedge clk);

    // LATENCY=4: reset drops an outstanding load, stores persist
    d_op(4, 32'h40, 32'hCAFEF00D, M_XWR, MT_W, 32'h0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    d_op(4, 32'h40, 32'h0, M_XRD, MT_W, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("l4_rst_valid", {31'b0, ifc4.d_resp_valid}, 32'h0);
    chk("l4_rst_data", ifc4.d_resp_data, 32'h0);
    chk("l4_rst_ready", {31'b0, ifc4.d_req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("l4_post_ready", {31'b0, ifc4.d_req_ready}, 32'h1);
    d_op(4, 32'h40, 32'h0, M_XRD, MT_W, 32'hCAFEF00D, 1'b0, 1'b1);
    d_op(4, 32'h43, 32'h0, M_XRD, MT_B, 32'hFFFFFFCA, 1'b0, 1'b1);

    repeat (10) @(negedge clk);
    chk("sb_drain", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
